// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states, constants and entry type for the fetch front end
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, FAULT, HALT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of fetch entries with flush; head is read straight from storage
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic rd, wr;
  assign dout = mem[rd];
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) mem[wr] <= din;
      wr    <= wr ^ push;
      rd    <= rd ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  end
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  always_ff @(posedge clk_i) begin
    if (reset_ni && !flush) assert (!(push && !pop && count == 2'd2)) else $error("fetch_fifo overflow");
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one imem read per cycle into a 2-entry decode FIFO
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 width_p    = 32,
  parameter logic [width_p-1:0] reset_pc_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  output logic [width_p-1:0] imem_pc_o,
  output logic               imem_stall_o,
  input  logic [width_p-1:0] imem_instr_i,
  input  logic               redirect_valid_i,
  input  logic [width_p-1:0] redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [width_p-1:0] instr_o,
  output logic [width_p-1:0] pc_o,
  output logic               fault_o
);
  if (reset_pc_p[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("reset_pc_p must be 4-byte aligned");
  end
  if (width_p != XLEN) begin : g_bad_width
    $error("width_p must match the entry width");
  end
  fetch_state_e state_q, state_d;
  logic [width_p-1:0] pc_q, inflight_pc_q;
  logic inflight_q, has, pop, push, space, issue;
  logic [1:0] count;
  fetch_entry_t head, entry;
  assign has           = count != 2'd0;
  assign instr_valid_o = has & ~redirect_valid_i;
  assign pop           = instr_valid_o & instr_ready_i;
  // the in-flight word already owns a slot, so it counts against space
  assign space         = ({1'b0, count} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2;
  assign issue         = (state_q == RUN) & space & ~redirect_valid_i;
  assign imem_stall_o  = ~issue;
  assign imem_pc_o     = pc_q;
  assign push          = ~redirect_valid_i & (inflight_q | state_q == FAULT);
  assign entry         = state_q == FAULT ? {NOP_INSTR, pc_q, 1'b1} : {imem_instr_i, inflight_pc_q, 1'b0};
  assign instr_o       = has ? head.instr : '0;
  assign pc_o          = has ? head.pc : '0;
  assign fault_o       = has & head.fault;
  fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .flush   (redirect_valid_i),
    .push    (push),
    .pop     (pop),
    .din     (entry),
    .dout    (head),
    .count   (count)
  );
  always_comb begin
    state_d = state_q;
    if (redirect_valid_i) state_d = redirect_pc_i[1:0] == 2'b00 ? RUN : FAULT;
    else if (state_q == BOOT) state_d = RUN;
    else if (state_q == FAULT) state_d = HALT;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= BOOT;
      pc_q          <= reset_pc_p;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= issue;
      inflight_pc_q <= issue ? pc_q : inflight_pc_q;
      pc_q          <= redirect_valid_i ? redirect_pc_i : issue ? pc_q + width_p'(4) : pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a sync-read memory returning addr+0x100
module tb_fetch_unit;
  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [31:0] imem_pc_o, imem_instr_i, redirect_pc_i, instr_o, pc_o;
  logic        imem_stall_o, redirect_valid_i, instr_valid_o, instr_ready_i, fault_o;
  logic [31:0] mem_q = '0;
  logic [64:0] log_q [$];
  int          errors = 0;
  int          checks = 0;

  fetch_unit dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .imem_pc_o       (imem_pc_o),
    .imem_stall_o    (imem_stall_o),
    .imem_instr_i    (imem_instr_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .fault_o         (fault_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (!imem_stall_o) mem_q <= imem_pc_o + 32'h100;
  assign imem_instr_i = mem_q;
  always @(negedge clk_i) if (reset_ni && instr_valid_o && instr_ready_i) log_q.push_back({fault_o, pc_o, instr_o});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [31:0] base, input int n);
    check({tag, "_len"}, 32'(log_q.size()), 32'(n));
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check({tag, "_pc"}, log_q[i][63:32], base + 32'(4 * i));
      check({tag, "_instr"}, log_q[i][31:0], base + 32'(4 * i) + 32'h100);
      check({tag, "_fault"}, 32'(log_q[i][64]), 0);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    instr_ready_i = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_valid", 32'(instr_valid_o), 0);
    check("rst_stall", 32'(imem_stall_o), 1);
    check("rst_imem_pc", imem_pc_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_fault", 32'(fault_o), 0);
    step();
    reset_ni = 1'b1;
    #1;
    check("boot_stall", 32'(imem_stall_o), 1);
    step(); #1;
    check("issue0_stall", 32'(imem_stall_o), 0);
    check("issue0_pc", imem_pc_o, 0);
    check("issue0_valid", 32'(instr_valid_o), 0);
    step(); #1;
    check("issue1_pc", imem_pc_o, 4);
    check("issue1_valid", 32'(instr_valid_o), 0);
    step(); #1;
    check("first_valid", 32'(instr_valid_o), 1);
    check("first_pc", pc_o, 0);
    check("first_instr", instr_o, 32'h100);
    step(); #1;
    check("second_pc", pc_o, 4);
    check("second_instr", instr_o, 32'h104);
    step();
    instr_ready_i = 1'b0;
    #1;
    check("hold_stall_comb", 32'(imem_stall_o), 1);
    repeat (5) begin
      step(); #1;
      check("hold_stall", 32'(imem_stall_o), 1);
      check("hold_pc", pc_o, 8);
    end
    step();
    instr_ready_i = 1'b1;
    repeat (7) step();
    step();
    instr_ready_i = 1'b0;
    repeat (3) step();
    #1;
    check("full_valid", 32'(instr_valid_o), 1);
    check("full_stall", 32'(imem_stall_o), 1);
    check("full_head_pc", pc_o, 32'h28);
    check_log("run", 0, 10);
    step();
    log_q.delete();
    instr_ready_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1;
    check("redir_valid", 32'(instr_valid_o), 0);
    check("redir_stall", 32'(imem_stall_o), 1);
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("redir_flushed", 32'(instr_valid_o), 0);
    check("redir_issue_pc", imem_pc_o, 32'h40);
    check("redir_issue_stall", 32'(imem_stall_o), 0);
    step(); #1;
    check("redir_r2_valid", 32'(instr_valid_o), 0);
    step(); #1;
    check("redir_r3_valid", 32'(instr_valid_o), 1);
    check("redir_r3_pc", pc_o, 32'h40);
    check("redir_r3_instr", instr_o, 32'h140);
    repeat (3) step();
    #1;
    check_log("redir", 32'h40, 3);
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h42;
    #1;
    check("mis_valid", 32'(instr_valid_o), 0);
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("mis_r1_valid", 32'(instr_valid_o), 0);
    check("mis_r1_stall", 32'(imem_stall_o), 1);
    check("mis_r1_imem_pc", imem_pc_o, 32'h42);
    step(); #1;
    check("mis_valid2", 32'(instr_valid_o), 1);
    check("mis_instr", instr_o, 32'h13);
    check("mis_pc", pc_o, 32'h42);
    check("mis_fault", 32'(fault_o), 1);
    step(); #1;
    check("halt_valid", 32'(instr_valid_o), 0);
    check("halt_stall", 32'(imem_stall_o), 1);
    repeat (3) step();
    #1;
    check("halt_valid_late", 32'(instr_valid_o), 0);
    check("halt_stall_late", 32'(imem_stall_o), 1);
    check("halt_imem_pc", imem_pc_o, 32'h42);
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h80;
    #1;
    check("resume_redir_valid", 32'(instr_valid_o), 0);
    step();
    redirect_valid_i = 1'b0;
    #1;
    check("resume_issue_pc", imem_pc_o, 32'h80);
    check("resume_issue_stall", 32'(imem_stall_o), 0);
    step();
    step(); #1;
    check("resume_valid", 32'(instr_valid_o), 1);
    check("resume_pc", pc_o, 32'h80);
    check("resume_instr", instr_o, 32'h180);
    check("resume_fault", 32'(fault_o), 0);
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_valid_i = 1'b0;
    step();
    step(); #1;
    check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    check("wrap_instr0", instr_o, 32'h0000_00FC);
    step(); #1;
    check("wrap_pc1", pc_o, 32'h0);
    check("wrap_instr1", instr_o, 32'h100);
    step();
    instr_ready_i = 1'b0;
    step();
    step(); #1;
    check("pend_valid", 32'(instr_valid_o), 1);
    #1;
    reset_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(instr_valid_o), 0);
    check("mid_rst_stall", 32'(imem_stall_o), 1);
    check("mid_rst_imem_pc", imem_pc_o, 0);
    check("mid_rst_pc", pc_o, 0);
    step();
    reset_ni = 1'b1;
    instr_ready_i = 1'b1;
    step(); #1;
    check("restart_issue_pc", imem_pc_o, 0);
    check("restart_issue_stall", 32'(imem_stall_o), 0);
    step();
    step(); #1;
    check("restart_valid", 32'(instr_valid_o), 1);
    check("restart_pc", pc_o, 0);
    check("restart_instr", instr_o, 32'h100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
